signed_mul_sequencer: RTL and testbench

//  Sequences one bit-serial signed multiply: accepts a 12-bit x/y pair on a valid/ready port,

---
 rtl/signed_mul_sequencer_pkg.sv | 19 +
 rtl/signed_mul_sequencer_if.sv | 27 ++
 rtl/signed_mul_sequencer_ser_shift_reg.sv | 31 +++
 rtl/signed_mul_sequencer.sv | 173 +++++++++++++++++
 tb/tb_signed_mul_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/signed_mul_sequencer_pkg.sv
// Shared definitions for the bit-serial signed multiply sequencer:
// default widths, watchdog limit and the FSM state encoding.
package signed_mul_sequencer_pkg;

  localparam int XW_DEF      = 12;
  localparam int ZW_DEF      = 24;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_F    = 3'd2,
    ST_MUL       = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_UNLOAD    = 3'd5,
    ST_RESP      = 3'd6
  } state_e;

endpackage

// File: rtl/signed_mul_sequencer_if.sv
// Host-side request/response handshake of the multiply sequencer.
// master = host front end, slave = sequencer.
interface signed_mul_sequencer_if
  import signed_mul_sequencer_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int ZW = ZW_DEF
);
  logic                 req_valid;
  logic                 req_ready;
  logic signed [XW-1:0] req_x;
  logic signed [XW-1:0] req_y;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic signed [ZW-1:0] rsp_z;
  logic                 rsp_err;

  modport master (
    output req_valid, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_err
  );

  modport slave (
    input  req_valid, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_err
  );
endinterface

// File: rtl/signed_mul_sequencer_ser_shift_reg.sv
// LSB-first shift register: parallel load / serial out, and serial in
// (at the MSB end) / parallel out.
module ser_shift_reg #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  input  logic         ser_in,
  output logic         ser_out,
  output logic [W-1:0] par_out
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= load_data;
    end else if (shift_en) begin
      data_q <= {ser_in, data_q[W-1:1]};
    end
  end

  assign ser_out = data_q[0];
  assign par_out = data_q;

endmodule

// File: rtl/signed_mul_sequencer.sv
// Drives one bit-serial signed multiply: serialises x/y into the multiplier,
// pulses mul, drains the product and returns it on the response handshake.
module signed_mul_sequencer
  import signed_mul_sequencer_pkg::*;
#(
  parameter int XW      = XW_DEF,
  parameter int ZW      = ZW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  signed_mul_sequencer_if.slave host,
  output logic x_in,
  output logic y_in,
  output logic sx,
  output logic sy,
  input  logic fx,
  input  logic fy,
  output logic mul,
  input  logic done,
  output logic sz,
  input  logic z_out,
  input  logic fz,
  output logic busy
);

  localparam int CW = $clog2(ZW + 1);
  localparam logic [CW-1:0] LAST_X = CW'(XW - 1);
  localparam logic [CW-1:0] LAST_Z = CW'(ZW - 1);
  localparam logic [7:0]    WD_MAX = 8'(TIMEOUT);

  state_e         state_q, state_d;
  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]     wd_q, wd_d;
  logic           err_q, err_d;
  logic           accept, shift_xy, shift_z, clr_z;
  logic           sx_q, mul_q, sz_q, rsp_valid_q, req_ready_q, busy_q;
  logic           x_ser, y_ser, z_ser;
  logic [XW-1:0]  x_par, y_par;
  logic [ZW-1:0]  z_par;
  logic           unused_bits;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : CW'(v + 1'b1);
  endfunction

  ser_shift_reg #(.W(XW)) u_x_sr (
    .clk(clk), .rst_n(rst_n), .load(accept), .load_data(host.req_x),
    .shift_en(shift_xy), .ser_in(1'b0), .ser_out(x_ser), .par_out(x_par)
  );

  ser_shift_reg #(.W(XW)) u_y_sr (
    .clk(clk), .rst_n(rst_n), .load(accept), .load_data(host.req_y),
    .shift_en(shift_xy), .ser_in(1'b0), .ser_out(y_ser), .par_out(y_par)
  );

  ser_shift_reg #(.W(ZW)) u_z_sr (
    .clk(clk), .rst_n(rst_n), .load(clr_z), .load_data('0),
    .shift_en(shift_z), .ser_in(z_out), .ser_out(z_ser), .par_out(z_par)
  );

  // Only the serial side of x/y and the parallel side of z are consumed.
  assign unused_bits = ^{x_par, y_par, z_ser};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    err_d     = err_q;
    accept    = 1'b0;
    shift_xy  = 1'b0;
    shift_z   = 1'b0;
    clr_z     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (host.req_valid) begin
          accept    = 1'b1;
          bit_cnt_d = '0;
          err_d     = 1'b0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        shift_xy  = 1'b1;
        bit_cnt_d = sat_inc(bit_cnt_q);
        if (bit_cnt_q == LAST_X) state_d = ST_WAIT_F;
      end
      ST_WAIT_F: begin
        if (fx && fy) begin
          state_d = ST_MUL;
        end else if (wd_q == WD_MAX) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_MUL: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (done) begin
          bit_cnt_d = '0;
          clr_z     = 1'b1;
          state_d   = ST_UNLOAD;
        end else if (wd_q == WD_MAX) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_UNLOAD: begin
        shift_z   = 1'b1;
        bit_cnt_d = sat_inc(bit_cnt_q);
        // fz must already be up while the last product bit is presented.
        if (bit_cnt_q == LAST_Z) begin
          err_d   = !fz;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (host.rsp_ready) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      wd_d = '0;
    end else if (state_q == ST_WAIT_F || state_q == ST_WAIT_DONE) begin
      wd_d = 8'(wd_q + 8'd1);
    end else begin
      wd_d = wd_q;
    end
  end

  // Strobes are registered from the next state so they are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
      sx_q        <= 1'b0;
      mul_q       <= 1'b0;
      sz_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      sx_q        <= (state_d == ST_LOAD);
      mul_q       <= (state_d == ST_MUL);
      sz_q        <= (state_d == ST_UNLOAD);
      rsp_valid_q <= (state_d == ST_RESP);
      req_ready_q <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign sx   = sx_q;
  assign sy   = sx_q;
  assign x_in = sx_q & x_ser;
  assign y_in = sx_q & y_ser;
  assign mul  = mul_q;
  assign sz   = sz_q;
  assign busy = busy_q;

  assign host.req_ready = req_ready_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_err   = err_q;
  assign host.rsp_z     = (rsp_valid_q && !err_q) ? signed'(z_par) : '0;

endmodule

// File: tb/tb_signed_mul_sequencer.sv
// Scoreboard bench for signed_mul_sequencer with a behavioural bit-serial
// signed multiplier attached to its serial ports.
module tb_signed_mul_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  signed_mul_sequencer_if #(.XW(12), .ZW(24)) hif ();

  logic x_in, y_in, sx, sy, fx, fy, mul, done, sz, z_out, fz, busy;

  signed_mul_sequencer #(.XW(12), .ZW(24), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .host(hif),
    .x_in(x_in), .y_in(y_in), .sx(sx), .sy(sy), .fx(fx), .fy(fy),
    .mul(mul), .done(done), .sz(sz), .z_out(z_out), .fz(fz), .busy(busy)
  );

  // ---------------- multiplier model ----------------
  logic signed [11:0] mx, my;
  logic signed [23:0] mz;
  int  mxc, myc, mzc, fy_wait, mcnt;
  logic running, done_m;
  int  fy_delay_cfg = 0;
  int  tmul_cfg = 3;
  logic done_en = 1'b1;

  assign fx    = (mxc == 12);
  assign fy    = (myc == 12) && (fy_wait >= fy_delay_cfg);
  assign done  = done_m;
  assign z_out = mz[0];
  assign fz    = (mzc >= 23);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mx <= '0; my <= '0; mz <= '0;
      mxc <= 0; myc <= 0; mzc <= 0; fy_wait <= 0; mcnt <= 0;
      running <= 1'b0; done_m <= 1'b0;
    end else begin
      if (sx) begin mx <= {x_in, mx[11:1]}; mxc <= mxc + 1; end
      if (sy) begin my <= {y_in, my[11:1]}; myc <= myc + 1; end
      if (myc == 12 && fy_wait < 1000) fy_wait <= fy_wait + 1;
      if (mul) begin
        mz <= mx * my;
        mxc <= 0; myc <= 0; fy_wait <= 0; mzc <= 0;
        mcnt <= tmul_cfg; running <= 1'b1; done_m <= 1'b0;
      end else if (running && done_en) begin
        if (mcnt <= 1) begin done_m <= 1'b1; running <= 1'b0; end
        else mcnt <= mcnt - 1;
      end
      if (sz) begin
        mz <= {1'b0, mz[23:1]};
        mzc <= mzc + 1;
        done_m <= 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  typedef struct {
    logic signed [23:0] z;
    logic               err;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rsp_cnt = 0, mul_cnt = 0, sx_cnt = 0, overlap = 0;
  int mul_cyc = 0, fy_cyc = 0;
  logic fy_prev = 1'b0;
  logic [11:0] xbits = '0, ybits = '0;

  always @(negedge clk) begin
    exp_t e;
    if (sx) begin
      xbits = {x_in, xbits[11:1]};
      ybits = {y_in, ybits[11:1]};
      sx_cnt++;
    end
    if (mul) begin mul_cnt++; mul_cyc = cyc; end
    if (fy && !fy_prev) fy_cyc = cyc;
    fy_prev = fy;
    if (int'(sx | sy) + int'(mul) + int'(sz) > 1) overlap++;
    if (hif.rsp_valid && hif.rsp_ready) begin
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("rsp_z", 32'(hif.rsp_z), 32'(e.z));
        check_eq("rsp_err", 32'(hif.rsp_err), 32'(e.err));
      end
    end
  end

  task automatic send(input logic signed [11:0] x, input logic signed [11:0] y,
                      input logic signed [23:0] z, input logic err);
    exp_t e;
    int n;
    e.z = z;
    e.err = err;
    @(posedge clk); #1;
    hif.req_x = x; hif.req_y = y; hif.req_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (hif.req_ready) break;
      n++;
      if (n > 2000) begin check_eq("accept_timeout", 32'd0, 32'd1); break; end
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    hif.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (rsp_cnt < target) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin check_eq("rsp_timeout", 32'(rsp_cnt), 32'(target)); break; end
    end
  endtask

  function automatic logic signed [23:0] prod(input logic signed [11:0] a, input logic signed [11:0] b);
    logic signed [23:0] p;
    p = a * b;
    return p;
  endfunction

  initial begin
    int s0, m0, r0, n;
    logic signed [23:0] z0;
    logic signed [11:0] rx, ry;

    hif.req_valid = 1'b0; hif.req_x = '0; hif.req_y = '0; hif.rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", 32'(hif.req_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_strobes", 32'({sx, sy, mul, sz}), 32'd0);
    check_eq("rst_rsp_valid", 32'(hif.rsp_valid), 32'd0);
    rst_n = 1'b1;

    // 3 x 5: serial bit pattern, single mul pulse, product 15
    s0 = sx_cnt; m0 = mul_cnt;
    send(12'sd3, 12'sd5, 24'sd15, 1'b0);
    wait_rsp(1);
    check_eq("t1_sx_cycles", 32'(sx_cnt - s0), 32'd12);
    check_eq("t1_x_bits", 32'(xbits), 32'h003);
    check_eq("t1_y_bits", 32'(ybits), 32'h005);
    check_eq("t1_mul_pulses", 32'(mul_cnt - m0), 32'd1);

    // signed corner products
    send(12'shFF9, 12'sd4, 24'shFFFFE4, 1'b0);
    send(-12'sd1, -12'sd1, 24'sd1, 1'b0);
    send(-12'sd2048, -12'sd2048, 24'sh400000, 1'b0);
    send(-12'sd2048, 12'sd2047, 24'shC00800, 1'b0);
    wait_rsp(5);
    for (int i = 0; i < 4; i++) begin
      rx = 12'($urandom); ry = 12'($urandom);
      send(rx, ry, prod(rx, ry), 1'b0);
    end
    wait_rsp(9);

    // back-pressure: response held, second request ignored
    hif.rsp_ready = 1'b0;
    send(12'sd100, -12'sd3, -24'sd300, 1'b0);
    n = 0;
    while (!hif.rsp_valid && n < 2000) begin @(negedge clk); n++; end
    check_eq("t3_rsp_valid_up", 32'(hif.rsp_valid), 32'd1);
    z0 = hif.rsp_z;
    @(posedge clk); #1;
    hif.req_x = 12'sd1; hif.req_y = 12'sd1; hif.req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("t3_hold_valid", 32'(hif.rsp_valid), 32'd1);
      check_eq("t3_hold_z", 32'(hif.rsp_z), 32'(z0));
      check_eq("t3_req_ready", 32'(hif.req_ready), 32'd0);
    end
    @(posedge clk); #1;
    hif.req_valid = 1'b0; hif.rsp_ready = 1'b1;
    wait_rsp(10);
    repeat (3) @(negedge clk);
    check_eq("t3_no_accept_busy", 32'(busy), 32'd0);
    check_eq("t3_no_accept_q", 32'(exp_q.size()), 32'd0);

    // fy arrives 7 cycles after fx
    fy_delay_cfg = 7; m0 = mul_cnt;
    send(12'sd5, -12'sd6, -24'sd30, 1'b0);
    wait_rsp(11);
    check_eq("t5_mul_pulses", 32'(mul_cnt - m0), 32'd1);
    check_eq("t5_mul_after_fy", 32'(mul_cyc - fy_cyc), 32'd1);
    fy_delay_cfg = 0;

    // done never arrives: watchdog abort, then a normal transaction
    done_en = 1'b0;
    send(12'sd9, 12'sd9, 24'sd0, 1'b1);
    wait_rsp(12);
    done_en = 1'b1;
    send(12'sd9, 12'sd9, 24'sd81, 1'b0);
    wait_rsp(13);

    // asynchronous reset at product bit 10
    send(12'sd100, -12'sd200, -24'sd20000, 1'b0);
    n = 0;
    while (!sz && n < 2000) begin @(negedge clk); n++; end
    check_eq("t6_reached_unload", 32'(sz), 32'd1);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_strobes", 32'({sx, sy, mul, sz}), 32'd0);
    check_eq("t6_req_ready", 32'(hif.req_ready), 32'd1);
    check_eq("t6_busy", 32'(busy), 32'd0);
    exp_q.delete();
    r0 = rsp_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("t6_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    check_eq("t6_rsp_valid", 32'(hif.rsp_valid), 32'd0);

    send(-12'sd7, -12'sd11, 24'sd77, 1'b0);
    wait_rsp(r0 + 1);
    check_eq("strobe_overlap", 32'(overlap), 32'd0);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
